flp_align_pipe: RTL and testbench

Parametrised, two-stage pipelined front end of the floating-point adder used in the Pseudo-Softmax datapath. It compares exponents, orders operands by magnitude, and right-aligns the smaller significand with guard/round/sticky bits, using a valid/ready handshake. Compared with the fixed 8-bit first-stage adder it generalises the exponent and mantissa widths, adds magnitude ordering, and adds backpressure. It feeds the significand add/normalise stage.

---
 rtl/flp_pkg.sv | 35 +++
 rtl/flp_sticky_shift.sv | 34 +++
 rtl/flp_align_pipe.sv | 147 ++++++++++++++
 tb/tb_flp_align_pipe.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/flp_pkg.sv
// Shared types and constants for the floating-point alignment front end.
// Defaults describe IEEE-754 single precision; modules take their own
// EXP_W/MAN_W parameters and derive significand width with sig_w().
package flp_pkg;

    localparam int unsigned DEF_EXP_W = 8;
    localparam int unsigned DEF_MAN_W = 23;

    // Aligned significand: {hidden, mantissa, guard, round, sticky}
    function automatic int unsigned sig_w(input int unsigned man_w);
        return man_w + 4;
    endfunction

    localparam int unsigned DEF_SIG_W = sig_w(DEF_MAN_W);

    localparam logic [DEF_EXP_W-1:0] EXP_ONES = '1;

    typedef struct packed {
        logic                 sign;
        logic [DEF_EXP_W-1:0] exp;
        logic [DEF_MAN_W-1:0] man;
    } operand_t;

    typedef struct packed {
        logic                 big_sign;
        logic                 small_sign;
        logic [DEF_EXP_W-1:0] big_exp;
        logic [DEF_EXP_W:0]   exp_diff;
        logic [DEF_SIG_W-1:0] big_sig;
        logic [DEF_SIG_W-1:0] small_sig;
        logic                 swapped;
        logic                 special;
    } aligned_t;

endpackage

// File: rtl/flp_sticky_shift.sv
// Combinational right shifter with sticky collection.
//   din  : significand to shift, LSB is the incoming sticky bit
//   sh   : unsigned shift amount
//   dout : din >> sh with every shifted-out bit ORed into the LSB;
//          shifts of SIG_W or more collapse to {0..0, |din}
module flp_sticky_shift #(
    parameter int unsigned SIG_W = 27,
    parameter int unsigned SH_W  = 9
) (
    input  logic [SIG_W-1:0] din,
    input  logic [SH_W-1:0]  sh,
    output logic [SIG_W-1:0] dout
);

    logic [SIG_W-1:0] shifted;
    logic [SIG_W-1:0] lost_mask;
    logic             lost;

    always_comb begin
        shifted   = '0;
        lost_mask = '0;
        lost      = 1'b0;
        dout      = '0;
        if (32'(sh) >= SIG_W) begin
            dout = {{(SIG_W-1){1'b0}}, |din};
        end else begin
            shifted   = din >> sh;
            lost_mask = ~({SIG_W{1'b1}} << sh);
            lost      = |(din & lost_mask);
            dout      = {shifted[SIG_W-1:1], shifted[0] | lost};
        end
    end

endmodule

// File: rtl/flp_align_pipe.sv
// Two-stage exponent compare / operand order / significand align front end
// of the FP adder, with valid/ready flow control on both stages.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : operand pair handshake (in_ready is combinational)
//   a_*/b_*               : operand sign, biased exponent, stored mantissa
//   out_valid/out_ready   : result handshake
//   big_*/small_*         : operands ordered by magnitude
//   exp_diff              : big_exp - small_exp, zero-extended
//   big_sig/small_sig     : {hidden, mantissa, G, R, S}; small_sig aligned
//   swapped               : b had the larger magnitude
//   special               : an exponent was all-ones; small_sig left unaligned
module flp_align_pipe
    import flp_pkg::*;
#(
    parameter  int unsigned EXP_W = DEF_EXP_W,
    parameter  int unsigned MAN_W = DEF_MAN_W,
    localparam int unsigned SIG_W = sig_w(MAN_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a_sign,
    input  logic             b_sign,
    input  logic [EXP_W-1:0] a_exp,
    input  logic [EXP_W-1:0] b_exp,
    input  logic [MAN_W-1:0] a_man,
    input  logic [MAN_W-1:0] b_man,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             big_sign,
    output logic             small_sign,
    output logic [EXP_W-1:0] big_exp,
    output logic [EXP_W:0]   exp_diff,
    output logic [SIG_W-1:0] big_sig,
    output logic [SIG_W-1:0] small_sig,
    output logic             swapped,
    output logic             special
);

    logic             ready1, ready2;
    logic             v1;

    // stage-1 combinational ordering
    logic [MAN_W-1:0] a_man_f, b_man_f;
    logic [SIG_W-1:0] a_sig, b_sig;
    logic             swap_c;
    logic             special_c;
    logic [EXP_W:0]   diff_c;

    // stage-1 registers
    logic             s1_big_sign, s1_small_sign;
    logic [EXP_W-1:0] s1_big_exp;
    logic [EXP_W:0]   s1_diff;
    logic [SIG_W-1:0] s1_big_sig, s1_small_sig;
    logic             s1_swapped, s1_special;

    logic [SIG_W-1:0] shifted_sig;
    logic [SIG_W-1:0] small_sig_next;

    assign ready2   = !out_valid || out_ready;
    assign ready1   = !v1 || ready2;
    assign in_ready = ready1;

    // Flush zero/denormal operands, then order by {exp, man} magnitude
    always_comb begin
        a_man_f   = (a_exp == '0) ? '0 : a_man;
        b_man_f   = (b_exp == '0) ? '0 : b_man;
        a_sig     = (a_exp == '0) ? '0 : {1'b1, a_man, 3'b000};
        b_sig     = (b_exp == '0) ? '0 : {1'b1, b_man, 3'b000};
        swap_c    = (b_exp > a_exp) || ((b_exp == a_exp) && (b_man_f > a_man_f));
        special_c = (a_exp == '1) || (b_exp == '1);
        diff_c    = swap_c ? ((EXP_W+1)'(b_exp) - (EXP_W+1)'(a_exp))
                           : ((EXP_W+1)'(a_exp) - (EXP_W+1)'(b_exp));
    end

    // Stage 1 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1            <= 1'b0;
            s1_big_sign   <= 1'b0;
            s1_small_sign <= 1'b0;
            s1_big_exp    <= '0;
            s1_diff       <= '0;
            s1_big_sig    <= '0;
            s1_small_sig  <= '0;
            s1_swapped    <= 1'b0;
            s1_special    <= 1'b0;
        end else begin
            if (ready1) begin
                v1 <= in_valid;
            end
            if (in_valid && ready1) begin
                s1_big_sign   <= swap_c ? b_sign : a_sign;
                s1_small_sign <= swap_c ? a_sign : b_sign;
                s1_big_exp    <= swap_c ? b_exp  : a_exp;
                s1_diff       <= diff_c;
                s1_big_sig    <= swap_c ? b_sig  : a_sig;
                s1_small_sig  <= swap_c ? a_sig  : b_sig;
                s1_swapped    <= swap_c;
                s1_special    <= special_c;
            end
        end
    end

    flp_sticky_shift #(
        .SIG_W (SIG_W),
        .SH_W  (EXP_W + 1)
    ) u_shift (
        .din  (s1_small_sig),
        .sh   (s1_diff),
        .dout (shifted_sig)
    );

    // inf/NaN payloads bypass alignment
    assign small_sig_next = s1_special ? s1_small_sig : shifted_sig;

    // Stage 2 register, drives the outputs directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            big_sign   <= 1'b0;
            small_sign <= 1'b0;
            big_exp    <= '0;
            exp_diff   <= '0;
            big_sig    <= '0;
            small_sig  <= '0;
            swapped    <= 1'b0;
            special    <= 1'b0;
        end else begin
            if (ready2) begin
                out_valid <= v1;
            end
            if (v1 && ready2) begin
                big_sign   <= s1_big_sign;
                small_sign <= s1_small_sign;
                big_exp    <= s1_big_exp;
                exp_diff   <= s1_diff;
                big_sig    <= s1_big_sig;
                small_sig  <= small_sig_next;
                swapped    <= s1_swapped;
                special    <= s1_special;
            end
        end
    end

endmodule

// File: tb/tb_flp_align_pipe.sv
module tb_flp_align_pipe;
    import flp_pkg::*;

    localparam int unsigned EW = DEF_EXP_W;
    localparam int unsigned MW = DEF_MAN_W;
    localparam int unsigned SW = DEF_SIG_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic          a_sign, b_sign;
    logic [EW-1:0] a_exp, b_exp;
    logic [MW-1:0] a_man, b_man;
    logic          out_valid, out_ready;
    logic          big_sign, small_sign;
    logic [EW-1:0] big_exp;
    logic [EW:0]   exp_diff;
    logic [SW-1:0] big_sig, small_sig;
    logic          swapped, special;

    flp_align_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_sign(a_sign), .b_sign(b_sign),
        .a_exp(a_exp), .b_exp(b_exp),
        .a_man(a_man), .b_man(b_man),
        .out_valid(out_valid), .out_ready(out_ready),
        .big_sign(big_sign), .small_sign(small_sign),
        .big_exp(big_exp), .exp_diff(exp_diff),
        .big_sig(big_sig), .small_sig(small_sig),
        .swapped(swapped), .special(special)
    );

    always #5 clk = ~clk;

    int       n_checks = 0;
    int       n_pass   = 0;
    aligned_t exp_q[$];
    aligned_t obs_last;
    logic     got_in, got_out;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Reference: magnitude compare on {exp,man}, alignment by integer division
    function automatic aligned_t model(input operand_t a, input operand_t b);
        aligned_t r;
        longint   am, bm, bsig, ssig, q, rem, p;
        int       d;
        operand_t bg, sm;
        am = (a.exp == 0) ? 0 : longint'({a.exp, a.man});
        bm = (b.exp == 0) ? 0 : longint'({b.exp, b.man});
        r.swapped = (bm > am);
        bg = r.swapped ? b : a;
        sm = r.swapped ? a : b;
        r.big_sign   = bg.sign;
        r.small_sign = sm.sign;
        r.big_exp    = bg.exp;
        d = int'(bg.exp) - int'(sm.exp);
        r.exp_diff = 9'(d);
        bsig = (bg.exp == 0) ? 0 : (longint'(1) << 26) + longint'(bg.man) * 8;
        ssig = (sm.exp == 0) ? 0 : (longint'(1) << 26) + longint'(sm.man) * 8;
        r.big_sig = 27'(bsig);
        r.special = (a.exp == EXP_ONES) || (b.exp == EXP_ONES);
        if (r.special) begin
            r.small_sig = 27'(ssig);
        end else if (d >= int'(SW)) begin
            r.small_sig = (ssig != 0) ? 27'd1 : 27'd0;
        end else begin
            p   = longint'(1) << d;
            q   = ssig / p;
            rem = ssig % p;
            r.small_sig = 27'(q | ((rem != 0) ? 1 : 0));
        end
        return r;
    endfunction

    function automatic aligned_t observe();
        aligned_t r;
        r = '{big_sign, small_sign, big_exp, exp_diff, big_sig, small_sig, swapped, special};
        return r;
    endfunction

    task automatic drive(input operand_t a, input operand_t b, input logic v);
        a_sign = a.sign; a_exp = a.exp; a_man = a.man;
        b_sign = b.sign; b_exp = b.exp; b_man = b.man;
        in_valid = v;
    endtask

    // One cycle: sample handshakes at negedge, score, then advance past posedge
    task automatic step();
        operand_t a, b;
        @(negedge clk);
        got_in  = in_valid && in_ready;
        got_out = out_valid && out_ready;
        if (out_valid) obs_last = observe();
        if (got_out) begin
            check("sb_nonempty", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) check("result", 128'(obs_last), 128'(exp_q.pop_front()));
        end
        if (got_in) begin
            a = '{a_sign, a_exp, a_man};
            b = '{b_sign, b_exp, b_man};
            exp_q.push_back(model(a, b));
        end
        @(posedge clk);
        #1;
    endtask

    // Push one pair into an empty pipe and wait (bounded) for its result
    task automatic single(input operand_t a, input operand_t b, output aligned_t r, output int lat);
        drive(a, b, 1'b1);
        step();
        check("accepted", 128'(got_in), 128'(1));
        in_valid = 1'b0;
        lat = 0;
        r = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            lat++;
            if (got_out) begin
                r = obs_last;
                break;
            end
        end
    endtask

    function automatic operand_t op(input logic s, input logic [EW-1:0] e, input logic [MW-1:0] m);
        operand_t o;
        o = '{s, e, m};
        return o;
    endfunction

    function automatic logic [EW-1:0] rnd_exp(input logic [EW-1:0] near);
        int unsigned mode;
        mode = $urandom_range(0, 7);
        case (mode)
            0:       return '0;
            1:       return '1;
            2, 3:    return EW'(int'(near) + $urandom_range(0, 30) - 15);
            default: return EW'($urandom);
        endcase
    endfunction

    initial begin
        aligned_t r, held;
        int       lat, acc, outs;
        logic     pending;
        operand_t ra, rb;

        rst_n = 1'b0; out_ready = 1'b1;
        drive('0, '0, 1'b0);
        obs_last = '0; got_in = 1'b0; got_out = 1'b0;

        #12;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_big_sig",   128'(big_sig),   128'(0));
        check("rst_small_sig", 128'(small_sig), 128'(0));
        check("rst_exp_diff",  128'(exp_diff),  128'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_rst", 128'(in_ready), 128'(1));

        // 1.0 + 0.5
        single(op(0, 127, 0), op(0, 126, 0), r, lat);
        check("t1_lat",       128'(lat),        128'(2));
        check("t1_big_exp",   128'(r.big_exp),  128'(127));
        check("t1_exp_diff",  128'(r.exp_diff), 128'(1));
        check("t1_swapped",   128'(r.swapped),  128'(0));
        check("t1_big_sig",   128'(r.big_sig),  128'('h4000000));
        check("t1_small_sig", 128'(r.small_sig),128'('h2000000));

        // equal exponents, b wins on mantissa
        single(op(0, 130, 23'h000001), op(1, 130, 23'h400000), r, lat);
        check("t2_swapped",   128'(r.swapped),   128'(1));
        check("t2_exp_diff",  128'(r.exp_diff),  128'(0));
        check("t2_big_sig",   128'(r.big_sig),   128'('h6000000));
        check("t2_small_sig", 128'(r.small_sig), 128'('h4000008));
        check("t2_big_sign",  128'(r.big_sign),  128'(1));

        // saturating shift
        single(op(0, 200, 0), op(0, 10, 23'h000001), r, lat);
        check("t3_exp_diff",  128'(r.exp_diff),  128'(190));
        check("t3_small_sig", 128'(r.small_sig), 128'(1));

        // shift of 25 leaves hidden bit at R and a sticky S
        single(op(0, 150, 0), op(0, 125, 23'h7FFFFF), r, lat);
        check("t4_exp_diff",  128'(r.exp_diff),  128'(25));
        check("t4_small_sig", 128'(r.small_sig), 128'(3));

        // zero flush
        single(op(0, 100, 23'h55), op(0, 0, 23'h123456), r, lat);
        check("t5_small_sig", 128'(r.small_sig), 128'(0));
        check("t5_exp_diff",  128'(r.exp_diff),  128'(100));
        check("t5_special",   128'(r.special),   128'(0));

        // inf/NaN: unaligned pass-through
        single(op(0, 8'hFF, 0), op(0, 120, 23'h5), r, lat);
        check("t6_special",   128'(r.special),   128'(1));
        check("t6_exp_diff",  128'(r.exp_diff),  128'(135));
        check("t6_small_sig", 128'(r.small_sig), 128'('h4000028));

        // backpressure: three pairs against a stalled sink
        out_ready = 1'b0;
        acc = 0;
        drive(op(0, 140, 23'h1), op(1, 139, 23'h2), 1'b1);
        for (int i = 0; i < 8 && acc < 2; i++) begin
            step();
            if (got_in) begin
                acc++;
                if (acc == 1) drive(op(1, 90, 23'h3), op(0, 95, 23'h4), 1'b1);
                if (acc == 2) drive(op(0, 60, 23'h5), op(0, 33, 23'h6), 1'b1);
            end
        end
        check("bp_two_accepted", 128'(acc), 128'(2));
        held = observe();
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_in_ready_low", 128'(in_ready), 128'(0));
            check("bp_out_valid",    128'(out_valid), 128'(1));
            check("bp_hold",         128'(obs_last), 128'(held));
        end
        out_ready = 1'b1;
        outs = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (got_in) in_valid = 1'b0;
            if (got_out) outs++;
        end
        check("bp_outs", 128'(outs), 128'(3));
        check("bp_drained", 128'(exp_q.size()), 128'(0));

        // async reset with both stages full
        out_ready = 1'b0;
        acc = 0;
        drive(op(0, 10, 23'h7), op(0, 9, 23'h8), 1'b1);
        for (int i = 0; i < 6 && acc < 2; i++) begin
            step();
            if (got_in) acc++;
        end
        in_valid = 1'b0;
        check("ar_full_valid", 128'(out_valid), 128'(1));
        check("ar_full_ready", 128'(in_ready),  128'(0));
        #2 rst_n = 1'b0;
        #1;
        check("ar_out_valid", 128'(out_valid), 128'(0));
        check("ar_big_sig",   128'(big_sig),   128'(0));
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        single(op(1, 77, 23'h1234), op(0, 80, 23'h4321), r, lat);
        check("ar_lat", 128'(lat), 128'(2));

        // randomized traffic with random backpressure
        pending = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pending) begin
                ra = op(1'($urandom), rnd_exp(8'd128), MW'($urandom));
                rb = op(1'($urandom), rnd_exp(ra.exp), MW'($urandom));
                if ($urandom_range(0, 7) == 0) rb.man = ra.man;
                drive(ra, rb, $urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            pending = in_valid && !got_in;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
        check("rnd_drained", 128'(exp_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
